// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry and the priority
// bypass used both by the read muxes and by the pipeline forwarding unit.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned NREAD_DEF = 2;

  // Widest address/data the shared helpers accept; callers zero-extend.
  localparam int unsigned MAX_AW   = 16;
  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [1:0] {
    FWD_ZERO  = 2'd0,
    FWD_WP0   = 2'd1,
    FWD_WP1   = 2'd2,
    FWD_STORE = 2'd3
  } fwd_sel_e;

  // Source of a read: x0, ALU write port, load write port, or storage.
  function automatic fwd_sel_e fwd_sel(
    input logic [MAX_AW-1:0] addr,
    input logic              we0,
    input logic [MAX_AW-1:0] wa0,
    input logic              we1,
    input logic [MAX_AW-1:0] wa1
  );
    fwd_sel_e sel;
    sel = FWD_STORE;
    if (addr == '0)                 sel = FWD_ZERO;
    else if (we0 && (wa0 == addr))  sel = FWD_WP0;
    else if (we1 && (wa1 == addr))  sel = FWD_WP1;
    return sel;
  endfunction

  // Forwarded read value for a given source selection.
  function automatic logic [MAX_XLEN-1:0] fwd_value(
    input fwd_sel_e            sel,
    input logic [MAX_XLEN-1:0] wd0,
    input logic [MAX_XLEN-1:0] wd1,
    input logic [MAX_XLEN-1:0] stored
  );
    logic [MAX_XLEN-1:0] val;
    val = '0;
    case (sel)
      FWD_ZERO:  val = '0;
      FWD_WP0:   val = wd0;
      FWD_WP1:   val = wd1;
      FWD_STORE: val = stored;
      default:   val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle between decode/write-back (master) and the
// register file (slave).
//   iRS/oREG_OUT/oRS_BUSY : packed read ports, port k at slice k
//   iWE0/iWA0/iWD0        : ALU write port
//   iWE1/iWA1/iWD1        : load write-back port (also clears busy)
//   iMARK/iMARK_ADDR      : mark a register busy (load issued)
//   oBUSY_CNT             : number of busy registers
interface regfile_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NREAD = 2
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NREAD*AW-1:0]   iRS;
  logic [NREAD*XLEN-1:0] oREG_OUT;
  logic [NREAD-1:0]      oRS_BUSY;
  logic                  iWE0;
  logic [AW-1:0]         iWA0;
  logic [XLEN-1:0]       iWD0;
  logic                  iWE1;
  logic [AW-1:0]         iWA1;
  logic [XLEN-1:0]       iWD1;
  logic                  iMARK;
  logic [AW-1:0]         iMARK_ADDR;
  logic [CW-1:0]         oBUSY_CNT;

  modport master (
    output iRS, iWE0, iWA0, iWD0, iWE1, iWA1, iWD1, iMARK, iMARK_ADDR,
    input  oREG_OUT, oRS_BUSY, oBUSY_CNT
  );

  modport slave (
    input  iRS, iWE0, iWA0, iWD0, iWE1, iWA1, iWD1, iMARK, iMARK_ADDR,
    output oREG_OUT, oRS_BUSY, oBUSY_CNT
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for outstanding long-latency (load) writes.
//   clk, rst            : clock, async active-high reset
//   rs                  : packed read addresses, port k at [k*AW +: AW]
//   we1, wa1            : load write-back, clears busy of wa1
//   mark, mark_addr     : set busy of mark_addr (mark beats a same-cycle clear)
//   rs_busy_c           : per-port busy, combinational, with clear bypass
//   busy_cnt            : registered popcount of the busy array
module reg_scoreboard #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NREAD = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREAD*$clog2(DEPTH)-1:0]    rs,
  input  logic                              we1,
  input  logic [$clog2(DEPTH)-1:0]          wa1,
  input  logic                              mark,
  input  logic [$clog2(DEPTH)-1:0]          mark_addr,
  output logic [NREAD-1:0]                  rs_busy_c,
  output logic [$clog2(DEPTH+1)-1:0]        busy_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_ev, clr_ev;

  // Next busy array and count delta; x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    set_ev = 1'b0;
    clr_ev = 1'b0;
    if (we1)  busy_d[wa1]       = 1'b0;
    if (mark) busy_d[mark_addr] = 1'b1;
    busy_d[0] = 1'b0;
    set_ev = mark && (mark_addr != '0) && !busy_q[mark_addr];
    clr_ev = we1 && (wa1 != '0) && busy_q[wa1] &&
             !(mark && (mark_addr == wa1));
    cnt_d  = cnt_q + CW'(set_ev) - CW'(clr_ev);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // A load completing this cycle already hides the busy bit.
  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [AW-1:0] ra;
    assign ra           = rs[k*AW +: AW];
    assign rs_busy_c[k] = (ra != '0) && busy_q[ra] && !(we1 && (wa1 == ra));
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, same-cycle
// write-to-read bypass, hard-wired x0 and a busy scoreboard for loads.
//   iCLK, iRST : clock, async active-high reset
//   bus        : register-file bundle (slave side), see regfile_mp_if
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NREAD = NREAD_DEF
) (
  input  logic         iCLK,
  input  logic         iRST,
  regfile_mp_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];

  // Write decode: port 1 first so port 0 wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (bus.iWE1) mem_d[bus.iWA1] = bus.iWD1;
    if (bus.iWE0) mem_d[bus.iWA0] = bus.iWD0;
    mem_d[0] = '0;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes with priority bypass from the in-flight writes.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    fwd_sel_e        sel;
    logic [XLEN-1:0] rd_val;

    assign ra  = bus.iRS[k*AW +: AW];
    assign sel = fwd_sel(MAX_AW'(ra), bus.iWE0, MAX_AW'(bus.iWA0),
                         bus.iWE1, MAX_AW'(bus.iWA1));
    assign rd_val = XLEN'(fwd_value(sel, MAX_XLEN'(bus.iWD0),
                                    MAX_XLEN'(bus.iWD1), MAX_XLEN'(mem_q[ra])));
    assign bus.oREG_OUT[k*XLEN +: XLEN] = rd_val;
  end

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk       (iCLK),
    .rst       (iRST),
    .rs        (bus.iRS),
    .we1       (bus.iWE1),
    .wa1       (bus.iWA1),
    .mark      (bus.iMARK),
    .mark_addr (bus.iMARK_ADDR),
    .rs_busy_c (bus.oRS_BUSY),
    .busy_cnt  (bus.oBUSY_CNT)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors on a 32x32, 2-read instance and a
// reference-model run on a 64-bit, 16-entry, 3-read instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .DEPTH(32), .NREAD(2)) ia ();
  regfile_mp_if #(.XLEN(64), .DEPTH(16), .NREAD(3)) ib ();

  regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2)) u_dut_a (
    .iCLK (clk), .iRST (rst), .bus (ia.slave)
  );
  regfile_mp #(.XLEN(64), .DEPTH(16), .NREAD(3)) u_dut_b (
    .iCLK (clk), .iRST (rst), .bus (ib.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.iWE0 = 1'b0; ia.iWA0 = '0; ia.iWD0 = '0;
    ia.iWE1 = 1'b0; ia.iWA1 = '0; ia.iWD1 = '0;
    ia.iMARK = 1'b0; ia.iMARK_ADDR = '0;
  endtask

  task automatic idle_b();
    ib.iWE0 = 1'b0; ib.iWA0 = '0; ib.iWD0 = '0;
    ib.iWE1 = 1'b0; ib.iWA1 = '0; ib.iWD1 = '0;
    ib.iMARK = 1'b0; ib.iMARK_ADDR = '0; ib.iRS = '0;
  endtask

  function automatic logic [63:0] rd_a(input int k);
    return 64'(ia.oREG_OUT[k*32 +: 32]);
  endfunction

  function automatic logic [63:0] bz_a(input int k);
    return 64'(ia.oRS_BUSY[k]);
  endfunction

  // Reference state for instance B
  logic [63:0] m_mem [16];
  logic [15:0] m_busy;

  initial begin
    rst = 1'b1;
    idle_a();
    idle_b();
    ia.iRS = {5'd6, 5'd5};
    #12;
    chk("rst_rd0", rd_a(0), 64'h0);
    chk("rst_rd1", rd_a(1), 64'h0);
    chk("rst_busy", 64'(ia.oRS_BUSY), 64'h0);
    chk("rst_cnt", 64'(ia.oBUSY_CNT), 64'h0);
    rst = 1'b0;
    tick();

    // ALU write bypass then storage
    ia.iWE0 = 1'b1; ia.iWA0 = 5'd3; ia.iWD0 = 32'hDEADBEEF;
    ia.iRS  = {5'd0, 5'd3};
    #1;
    chk("byp_x3", rd_a(0), 64'hDEADBEEF);
    chk("byp_x0", rd_a(1), 64'h0);
    tick(); idle_a(); #1;
    chk("stored_x3", rd_a(0), 64'hDEADBEEF);
    tick(); #1;
    chk("stored_x3_later", rd_a(0), 64'hDEADBEEF);

    // x0 is never written and never busy
    ia.iWE0 = 1'b1; ia.iWA0 = 5'd0; ia.iWD0 = 32'hFFFFFFFF;
    ia.iMARK = 1'b1; ia.iMARK_ADDR = 5'd0;
    ia.iRS = {5'd0, 5'd0};
    #1;
    chk("x0_byp", rd_a(0), 64'h0);
    chk("x0_busy_now", bz_a(0), 64'h0);
    tick(); idle_a(); #1;
    chk("x0_stored", rd_a(1), 64'h0);
    chk("x0_busy", bz_a(0), 64'h0);
    chk("x0_cnt", 64'(ia.oBUSY_CNT), 64'h0);

    // Collision on x7, which was busy beforehand
    ia.iMARK = 1'b1; ia.iMARK_ADDR = 5'd7;
    ia.iRS = {5'd7, 5'd7};
    tick(); idle_a(); #1;
    chk("x7_busy", bz_a(0), 64'h1);
    chk("x7_cnt1", 64'(ia.oBUSY_CNT), 64'h1);
    ia.iWE0 = 1'b1; ia.iWA0 = 5'd7; ia.iWD0 = 32'h11;
    ia.iWE1 = 1'b1; ia.iWA1 = 5'd7; ia.iWD1 = 32'h22;
    #1;
    chk("coll_byp0", rd_a(0), 64'h11);
    chk("coll_byp1", rd_a(1), 64'h11);
    chk("coll_busy_clr", bz_a(1), 64'h0);
    tick(); idle_a(); #1;
    chk("coll_stored", rd_a(0), 64'h11);
    chk("coll_busy_after", bz_a(0), 64'h0);
    chk("coll_cnt0", 64'(ia.oBUSY_CNT), 64'h0);

    // Scoreboard on x9
    ia.iMARK = 1'b1; ia.iMARK_ADDR = 5'd9;
    ia.iRS = {5'd9, 5'd3};
    #1;
    chk("mark_not_yet", bz_a(1), 64'h0);
    tick(); idle_a(); #1;
    chk("mark_busy", bz_a(1), 64'h1);
    chk("mark_cnt", 64'(ia.oBUSY_CNT), 64'h1);
    chk("mark_other_port", bz_a(0), 64'h0);
    ia.iMARK = 1'b1; ia.iMARK_ADDR = 5'd9;
    ia.iWE1 = 1'b1; ia.iWA1 = 5'd9; ia.iWD1 = 32'h55;
    #1;
    chk("markclr_byp", rd_a(1), 64'h55);
    tick(); idle_a(); #1;
    chk("markclr_data", rd_a(1), 64'h55);
    chk("markclr_busy", bz_a(1), 64'h1);
    chk("markclr_cnt", 64'(ia.oBUSY_CNT), 64'h1);
    ia.iWE1 = 1'b1; ia.iWA1 = 5'd9; ia.iWD1 = 32'h66;
    #1;
    chk("clr_busy_now", bz_a(1), 64'h0);
    chk("clr_byp", rd_a(1), 64'h66);
    chk("clr_cnt_still", 64'(ia.oBUSY_CNT), 64'h1);
    tick(); idle_a(); #1;
    chk("clr_cnt0", 64'(ia.oBUSY_CNT), 64'h0);
    chk("clr_busy_after", bz_a(1), 64'h0);

    // Async reset mid-run
    ia.iWE0 = 1'b1; ia.iWA0 = 5'd5; ia.iWD0 = 32'h1234;
    tick(); idle_a();
    ia.iMARK = 1'b1; ia.iMARK_ADDR = 5'd6;
    tick(); idle_a();
    ia.iRS = {5'd6, 5'd5};
    #1;
    chk("pre_rst_x5", rd_a(0), 64'h1234);
    chk("pre_rst_busy6", bz_a(1), 64'h1);
    chk("pre_rst_cnt", 64'(ia.oBUSY_CNT), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd0", rd_a(0), 64'h0);
    chk("mid_rst_rd1", rd_a(1), 64'h0);
    chk("mid_rst_busy", 64'(ia.oRS_BUSY), 64'h0);
    chk("mid_rst_cnt", 64'(ia.oBUSY_CNT), 64'h0);
    #10;
    rst = 1'b0;
    tick(); #1;
    chk("post_rst_x5", rd_a(0), 64'h0);
    chk("post_rst_busy6", bz_a(1), 64'h0);

    // Reference-model run on instance B
    rst = 1'b1;
    idle_b();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_busy = '0;
    #3;
    rst = 1'b0;
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [3:0]  ra;
      logic [63:0] exp_rd;
      logic        exp_bz;
      ib.iWE0 = ($urandom_range(0, 1) == 1);
      ib.iWA0 = 4'($urandom_range(0, 15));
      ib.iWD0 = {$urandom, $urandom};
      ib.iWE1 = ($urandom_range(0, 2) == 0);
      ib.iWA1 = 4'($urandom_range(0, 15));
      ib.iWD1 = {$urandom, $urandom};
      ib.iMARK = ($urandom_range(0, 2) == 0);
      ib.iMARK_ADDR = 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) ib.iRS[k*4 +: 4] = 4'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 3; k++) begin
        ra = ib.iRS[k*4 +: 4];
        if (ra == 4'd0)                        exp_rd = '0;
        else if (ib.iWE0 && ib.iWA0 == ra)     exp_rd = ib.iWD0;
        else if (ib.iWE1 && ib.iWA1 == ra)     exp_rd = ib.iWD1;
        else                                   exp_rd = m_mem[ra];
        exp_bz = (ra != 4'd0) && m_busy[ra] && !(ib.iWE1 && ib.iWA1 == ra);
        chk($sformatf("rnd_rd%0d_c%0d", k, cyc), ib.oREG_OUT[k*64 +: 64], exp_rd);
        chk($sformatf("rnd_bz%0d_c%0d", k, cyc), 64'(ib.oRS_BUSY[k]), 64'(exp_bz));
      end
      chk($sformatf("rnd_cnt_c%0d", cyc), 64'(ib.oBUSY_CNT), 64'($countones(m_busy)));
      if (ib.iWE1 && ib.iWA1 != 4'd0) m_mem[ib.iWA1] = ib.iWD1;
      if (ib.iWE0 && ib.iWA0 != 4'd0) m_mem[ib.iWA0] = ib.iWD0;
      if (ib.iWE1) m_busy[ib.iWA1] = 1'b0;
      if (ib.iMARK && ib.iMARK_ADDR != 4'd0) m_busy[ib.iMARK_ADDR] = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core pipeline: configurable width, depth and read-port count, two write ports (ALU and load write-back), same-cycle write-to-read bypass, hard-wired zero register, and a per-register busy scoreboard for outstanding long-latency writes. It sits between decode (reads, busy checks) and write-back (writes), replacing the single-write, two-read register file. Debug printing is not part of this block.

## Interface
- XLEN, 32: register width in bits.
- DEPTH, 32: number of registers; power of two, >= 2.
- NREAD, 2: number of read ports, 1..4.
- AW, $clog2(DEPTH): address width (derived, not overridden).
- iCLK  in  1  clock; all state updates on rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iRS  in  NREAD*AW  read addresses; port k at bits [k*AW +: AW].
- oREG_OUT  out  NREAD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
- oRS_BUSY  out  NREAD  port k's register has a pending long-latency write.
- iWE0, iWA0 (AW), iWD0 (XLEN)  in  ALU write port.
- iWE1, iWA1 (AW), iWD1 (XLEN)  in  load write-back port; also clears busy.
- iMARK  in  1  set busy for iMARK_ADDR (load issued).
- iMARK_ADDR  in  AW  register to mark busy.
- oBUSY_CNT  out  $clog2(DEPTH+1)  number of busy registers.

## Operation
- Storage: DEPTH x XLEN flops; register 0 is constant zero, never written, never busy.
- Writes: on rising edge, iWE0 writes iWD0 to iWA0, iWE1 writes iWD1 to iWA1; writes to address 0 are dropped.
- Same-address collision (both enables, iWA0 == iWA1, nonzero): port 0 data stored.
- Reads are combinational per port: address 0 -> 0; else if iWE0 && iWA0 == addr -> iWD0; else if iWE1 && iWA1 == addr -> iWD1; else stored value.
- Scoreboard: busy[DEPTH] bits. Rising edge: iWE1 to addr a clears busy[a]; iMARK sets busy[iMARK_ADDR]. Mark and clear to the same address in one cycle -> bit ends set (mark wins). iMARK_ADDR == 0 ignored. Marking an already-busy register leaves it busy (no nesting). iWE0 never affects busy.
- oRS_BUSY[k] combinational: busy[addr] && !(iWE1 && iWA1 == addr); address 0 -> 0. Same-cycle mark is not visible until next cycle.
- oBUSY_CNT: registered counter, next = cnt + set_event - clear_event, where set_event = mark of a non-busy nonzero register, clear_event = iWE1 to a busy register not re-marked the same cycle. Always equals popcount(busy).

## Timing
- iRST high (async): all registers 0, busy all 0, oBUSY_CNT 0; oREG_OUT then reads 0 for every port unless bypassed by a write in flight; oRS_BUSY 0. Reset during any activity discards pending writes and marks.
- Write latency: data visible on oREG_OUT in the same cycle via bypass, from storage from next cycle onward.
- Busy latency: mark -> oRS_BUSY high from the next cycle; clear -> oRS_BUSY low in the same cycle as the iWE1 write.
- oBUSY_CNT updates one cycle after the causing edge inputs (registered).
- No handshake: all inputs sampled every edge; caller guarantees iWE*/iMARK are valid-qualified.

## Structure
- Package regfile_pkg: default XLEN/DEPTH/NREAD constants, and a function computing the forwarded read value (priority bypass) for reuse by the pipeline forwarding unit.
- Sub-module reg_scoreboard: busy bit array, mark/clear priority, oBUSY_CNT counter, per-port busy lookup with clear-bypass.
- Top regfile_mp: storage array, write decode, read muxes with bypass, x0 gating.

## Test plan
- Reset: assert iRST mid-run after writing x5 = 0x1234 and marking x6 -> all oREG_OUT 0, oRS_BUSY 0, oBUSY_CNT 0 immediately, x5 reads 0 after release.
- Write/read/bypass: iWE0 x3 = 0xDEADBEEF with iRS port 0 = 3 same cycle -> oREG_OUT port 0 = 0xDEADBEEF that cycle and every later cycle.
- Zero register: iWE0 x0 = 0xFFFFFFFF, iMARK x0 -> x0 reads 0, oRS_BUSY 0, oBUSY_CNT stays 0.
- Collision: iWE0 x7 = 0x11, iWE1 x7 = 0x22 same cycle -> read bypass 0x11, stored 0x11; busy of x7 cleared if previously set.
- Scoreboard: mark x9 -> next cycle oRS_BUSY high, oBUSY_CNT 1; mark x9 and iWE1 x9 = 0x55 same cycle -> x9 = 0x55, still busy, count 1; iWE1 x9 alone -> busy low same cycle, count 0 next.
- Parameters: XLEN = 64, DEPTH = 16, NREAD = 3 -> random writes/reads match a reference model for 10k cycles, all ports independent.
